// File: rtl/alarm_pkg.sv
// Shared alarm FSM state encoding, used by alarm_ctrl and the display/LED stage.
package alarm_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StRing   = 2'd2,
        StSnooze = 2'd3
    } alarm_state_e;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles its output every HP enabled clocks, clear restarts phase.
module tone_gen #(
    parameter int unsigned HP = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tone
);
    localparam int unsigned HpEff = (HP == 0) ? 1 : HP;
    localparam int unsigned CntW  = (HpEff > 1) ? $clog2(HpEff) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (clear) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (enable) begin
            if (cnt_q == CntW'(HpEff - 1)) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: time match, ring timeout, stop button and buzzer tone.
// Optional snooze state is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned TONE_HZ    = 1000,
    parameter int unsigned RING_SEC   = 30,
    parameter int unsigned SNOOZE_SEC = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        i_sec,
    input  logic [5:0]        i_min,
    input  logic [5:0]        i_alarm_sec,
    input  logic [5:0]        i_alarm_min,
    input  logic              i_alarm_en,
    input  logic              i_stop,
    input  logic              i_snooze,
    output logic              o_buzz,
    output logic              o_ringing,
    output logic [StateW-1:0] o_state
);
    localparam int unsigned HP = CLK_HZ / (2 * TONE_HZ);

    alarm_state_e state_q, state_d;
    logic [5:0]   sec_prev_q;
    logic [5:0]   ring_cnt_q, ring_cnt_d;
    logic         sec_tick_q;
    logic         stop_q, stop_rise;
    logic         time_match;
    logic         ringing, tone_clear, tone;

    // Alarm fields above 59 can never equal a valid time.
    assign time_match = (i_alarm_sec <= 6'd59) && (i_alarm_min <= 6'd59) &&
                        (i_sec == i_alarm_sec) && (i_min == i_alarm_min);
    assign stop_rise  = i_stop & ~stop_q;

`ifdef ALARM_SNOOZE_EN
    logic [7:0] snooze_cnt_q, snooze_cnt_d;
    logic       snooze_q, snooze_rise;

    assign snooze_rise = i_snooze & ~snooze_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snooze_cnt_q <= '0;
            snooze_q     <= 1'b0;
        end else begin
            snooze_cnt_q <= snooze_cnt_d;
            snooze_q     <= i_snooze;
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = i_snooze ^ (^8'(SNOOZE_SEC));
`endif

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif
        if (!i_alarm_en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (sec_tick_q && time_match) begin
                        state_d    = StRing;
                        ring_cnt_d = 6'(RING_SEC);
                    end
                end
                StRing: begin
                    if (stop_rise) begin
                        state_d = StArmed;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_rise) begin
                        state_d      = StSnooze;
                        snooze_cnt_d = 8'(SNOOZE_SEC);
                    end
`endif
                    else if (sec_tick_q) begin
                        ring_cnt_d = ring_cnt_q - 6'd1;
                        if (ring_cnt_q == 6'd1) state_d = StArmed;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                StSnooze: begin
                    if (stop_rise) begin
                        state_d = StArmed;
                    end else if (sec_tick_q) begin
                        snooze_cnt_d = snooze_cnt_q - 8'd1;
                        if (snooze_cnt_q == 8'd1) begin
                            state_d    = StRing;
                            ring_cnt_d = 6'(RING_SEC);
                        end
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sec_prev_q <= '0;
            sec_tick_q <= 1'b0;
            stop_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sec_prev_q <= i_sec;
            sec_tick_q <= (i_sec != sec_prev_q);
            stop_q     <= i_stop;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign ringing    = (state_q == StRing);
    assign tone_clear = (state_d == StRing) && (state_q != StRing);

    tone_gen #(
        .HP(HP)
    ) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(ringing),
        .clear (tone_clear),
        .tone  (tone)
    );

    // Gated by the async-reset state so reset silences the buzzer without a clock.
    assign o_buzz    = tone & ringing;
    assign o_ringing = ringing;
    assign o_state   = state_q;

endmodule
